// File: rtl/sprite_blitter_if.sv
// Bus between the sprite blitter and its sequencer, sprite ROM and framebuffer.
// With SPRITE_BLITTER_FLIP_V_EN defined, the request also carries flip_v.
interface sprite_blitter_if #(
  parameter int unsigned RomAw = 8,
  parameter int unsigned FbAw  = 17
);
  logic                    start;
  logic signed [10:0]      sprite_x;
  logic signed [10:0]      sprite_y;
  logic                    flip_h;
`ifdef SPRITE_BLITTER_FLIP_V_EN
  logic                    flip_v;
`endif
  logic                    busy;
  logic                    done;
  logic        [RomAw-1:0] rom_addr;
  logic        [3:0]       rom_q;
  logic                    fb_we;
  logic        [FbAw-1:0]  fb_addr;
  logic        [3:0]       fb_data;

  // Blitter side.
  modport slave (
`ifdef SPRITE_BLITTER_FLIP_V_EN
    input  flip_v,
`endif
    input  start, sprite_x, sprite_y, flip_h, rom_q,
    output busy, done, rom_addr, fb_we, fb_addr, fb_data
  );

  // Sequencer / memory side.
  modport master (
`ifdef SPRITE_BLITTER_FLIP_V_EN
    output flip_v,
`endif
    output start, sprite_x, sprite_y, flip_h, rom_q,
    input  busy, done, rom_addr, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/sprite_blitter.sv
// Copies one palette-indexed sprite from ROM into the framebuffer with flip, transparency and
// per-pixel clipping. SPRITE_BLITTER_FLIP_V_EN adds vertical flip.
module sprite_blitter #(
  parameter int unsigned SprW           = 16,
  parameter int unsigned SprH           = 16,
  parameter int unsigned FbW            = 320,
  parameter int unsigned FbH            = 240,
  parameter int unsigned RomAw          = 8,
  parameter int unsigned FbAw           = 17,
  parameter logic [3:0]  TransparentIdx = 4'd0
) (
  input logic              vga_clk_i,
  input logic              reset_ni,
  sprite_blitter_if.slave  bus_io
);
  localparam int unsigned ColW = $clog2(SprW);
  localparam int unsigned RowW = $clog2(SprH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                    state_q, state_d;
  logic        [ColW-1:0]    col_q, col_d;
  logic        [RowW-1:0]    row_q, row_d;
  logic signed [10:0]        x_q, x_d, y_q, y_d;
  logic                      flip_h_q, flip_h_d;
`ifdef SPRITE_BLITTER_FLIP_V_EN
  logic                      flip_v_q, flip_v_d;
`endif

  logic        [RomAw-1:0]   rom_addr_q, rom_addr_d;
  logic signed [10:0]        tx1_q, tx1_d, ty1_q, ty1_d;
  logic                      v1_q;
  logic signed [10:0]        tx2_q, ty2_q;
  logic                      v2_q;
  logic                      fb_we_q, fb_we_d;
  logic        [FbAw-1:0]    fb_addr_q, fb_addr_d;
  logic        [3:0]         fb_data_q, fb_data_d;

  // Pixel being issued this cycle and the draw parameters it uses.
  logic                      issue;
  logic        [ColW-1:0]    pcol, rcol;
  logic        [RowW-1:0]    prow, rrow;
  logic signed [10:0]        bx, by;
  logic                      fh, fv;
  logic                      last_col, tx_ok, ty_ok, wr;

  assign last_col = (col_q == ColW'(SprW - 1));

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    flip_h_d = flip_h_q;
    issue    = 1'b0;
    pcol     = col_q;
    prow     = row_q;
    bx       = x_q;
    by       = y_q;
    fh       = flip_h_q;
`ifdef SPRITE_BLITTER_FLIP_V_EN
    flip_v_d = flip_v_q;
    fv       = flip_v_q;
`else
    fv       = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          // Pixel 0 is issued straight from the request so rom_addr leads by one cycle.
          state_d  = StRun;
          x_d      = bus_io.sprite_x;
          y_d      = bus_io.sprite_y;
          flip_h_d = bus_io.flip_h;
          issue    = 1'b1;
          pcol     = '0;
          prow     = '0;
          bx       = bus_io.sprite_x;
          by       = bus_io.sprite_y;
          fh       = bus_io.flip_h;
`ifdef SPRITE_BLITTER_FLIP_V_EN
          flip_v_d = bus_io.flip_v;
          fv       = bus_io.flip_v;
`endif
        end
      end
      StRun: begin
        if (last_col && (row_q == RowW'(SprH - 1))) begin
          state_d = StDrain;
        end else begin
          issue = 1'b1;
          if (last_col) begin
            pcol = '0;
            prow = row_q + RowW'(1);
          end else begin
            pcol = col_q + ColW'(1);
          end
        end
      end
      StDrain: begin
        if (!v1_q && !v2_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    col_d      = issue ? pcol : col_q;
    row_d      = issue ? prow : row_q;
    rcol       = fh ? (ColW'(SprW - 1) - pcol) : pcol;
    rrow       = fv ? (RowW'(SprH - 1) - prow) : prow;
    rom_addr_d = issue ? RomAw'(32'(rrow) * SprW + 32'(rcol)) : rom_addr_q;
    tx1_d      = issue ? (bx + $signed(11'(pcol))) : tx1_q;
    ty1_d      = issue ? (by + $signed(11'(prow))) : ty1_q;
  end

  // Write stage: rom_q is valid now for the pixel whose coordinates sit in stage 2.
  always_comb begin
    tx_ok     = !tx2_q[10] && ($unsigned(tx2_q) < 11'(FbW));
    ty_ok     = !ty2_q[10] && ($unsigned(ty2_q) < 11'(FbH));
    wr        = v2_q && tx_ok && ty_ok && (bus_io.rom_q != TransparentIdx);
    fb_we_d   = wr;
    fb_addr_d = wr ? FbAw'(32'($unsigned(ty2_q)) * FbW + 32'($unsigned(tx2_q))) : fb_addr_q;
    fb_data_d = wr ? bus_io.rom_q : fb_data_q;
  end

  always_ff @(posedge vga_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      flip_h_q   <= 1'b0;
`ifdef SPRITE_BLITTER_FLIP_V_EN
      flip_v_q   <= 1'b0;
`endif
      rom_addr_q <= '0;
      tx1_q      <= '0;
      ty1_q      <= '0;
      v1_q       <= 1'b0;
      tx2_q      <= '0;
      ty2_q      <= '0;
      v2_q       <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      x_q        <= x_d;
      y_q        <= y_d;
      flip_h_q   <= flip_h_d;
`ifdef SPRITE_BLITTER_FLIP_V_EN
      flip_v_q   <= flip_v_d;
`endif
      rom_addr_q <= rom_addr_d;
      tx1_q      <= tx1_d;
      ty1_q      <= ty1_d;
      v1_q       <= issue;
      tx2_q      <= tx1_q;
      ty2_q      <= ty1_q;
      v2_q       <= v1_q;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
    end
  end

  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.done     = (state_q == StDone);
  assign bus_io.rom_addr = rom_addr_q;
  assign bus_io.fb_we    = fb_we_q;
  assign bus_io.fb_addr  = fb_addr_q;
  assign bus_io.fb_data  = fb_data_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: a pixel-list model of the draw is compared against
// logged framebuffer writes, ROM addresses, busy and done.
module tb_sprite_blitter;
  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   abs_cyc = 0;
  int   t0 = 0;
  bit   log_en = 1'b0;

  logic [3:0] rom_mem [0:255];
  int         rom_seen [0:599];
  bit         busy_seen [0:599];
  int         exp_ra [0:599];
  wr_t        wr_q [$];
  wr_t        exp_wr [$];
  int         done_q [$];

  sprite_blitter_if #(.RomAw(8), .FbAw(17)) bus ();

  sprite_blitter dut (
    .vga_clk_i (clk),
    .reset_ni  (rst_n),
    .bus_io    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  // Synchronous sprite ROM.
  always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_addr];

  always @(negedge clk) begin
    if (log_en && (abs_cyc - t0) >= 0 && (abs_cyc - t0) < 600) begin
      rom_seen[abs_cyc - t0]  <= int'(bus.rom_addr);
      busy_seen[abs_cyc - t0] <= bus.busy;
      if (bus.done) done_q.push_back(abs_cyc - t0);
      if (bus.fb_we) wr_q.push_back('{abs_cyc - t0, int'(bus.fb_addr), int'(bus.fb_data)});
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp, output bit ok);
    checks++;
    ok = (obs === exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint pack(input wr_t w);
    return (longint'(w.cyc) << 32) | (longint'(w.addr) << 4) | longint'(w.data);
  endfunction

  // mode 0: all opaque (addr%15)+1; 1: left half transparent; 2: random with many zeros
  task automatic load_rom(input int mode);
    for (int a = 0; a < 256; a++) begin
      case (mode)
        0: rom_mem[a] = 4'((a % 15) + 1);
        1: rom_mem[a] = ((a % 16) < 8) ? 4'd0 : 4'((a % 15) + 1);
        default: rom_mem[a] = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
      endcase
    end
  endtask

  // Every sprite pixel k is read in cycle off+1+k and, if visible, written in cycle off+3+k.
  task automatic build_exp(input int x, input int y, input bit fh, input int off);
    int col, row, src_a, tx, ty;
    for (int k = 0; k < 256; k++) begin
      row   = k / 16;
      col   = k % 16;
      src_a = row * 16 + (fh ? 15 - col : col);
      tx    = x + col;
      ty    = y + row;
      exp_ra[off + 1 + k] = src_a;
      if (tx >= 0 && tx < 320 && ty >= 0 && ty < 240 && rom_mem[src_a] != 4'd0)
        exp_wr.push_back('{off + 3 + k, ty * 320 + tx, int'(rom_mem[src_a])});
    end
  endtask

  task automatic compare(input string tag, input int ndraw, input int win);
    bit ok;
    int bad;
    bit eb;
    check({tag, ".nwr"}, wr_q.size(), exp_wr.size(), ok);
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      check({tag, ".wr"}, pack(wr_q[i]), pack(exp_wr[i]), ok);
      if (!ok) break;
    end
    bad = 0;
    for (int c = 0; c < win; c++)
      if (exp_ra[c] >= 0 && rom_seen[c] != exp_ra[c]) bad++;
    check({tag, ".rom_addr_bad"}, bad, 0, ok);
    bad = 0;
    for (int c = 0; c < win; c++) begin
      eb = 1'b0;
      for (int d = 0; d < ndraw; d++)
        if (c >= d * 260 + 1 && c <= d * 260 + 259) eb = 1'b1;
      if (busy_seen[c] != eb) bad++;
    end
    check({tag, ".busy_bad"}, bad, 0, ok);
    check({tag, ".ndone"}, done_q.size(), ndraw, ok);
    for (int d = 0; d < done_q.size() && d < ndraw; d++)
      check({tag, ".done_cyc"}, done_q[d], d * 260 + 259, ok);
  endtask

  task automatic run(input string tag, input int x, input int y, input bit fh,
                     input int hold, input int ndraw);
    int win;
    win = (ndraw == 2) ? 560 : 280;
    exp_wr.delete();
    wr_q.delete();
    done_q.delete();
    foreach (exp_ra[i]) exp_ra[i] = -1;
    for (int d = 0; d < ndraw; d++) build_exp(x, y, fh, d * 260);
    @(posedge clk);
    #1;
    bus.sprite_x = 11'(x);
    bus.sprite_y = 11'(y);
    bus.flip_h   = fh;
    bus.start    = 1'b1;
    t0           = abs_cyc;
    log_en       = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (win - hold) @(posedge clk);
    #1;
    log_en = 1'b0;
    compare(tag, ndraw, win);
  endtask

  initial begin
    bit ok;
    bus.start    = 1'b0;
    bus.sprite_x = '0;
    bus.sprite_y = '0;
    bus.flip_h   = 1'b0;
`ifdef SPRITE_BLITTER_FLIP_V_EN
    bus.flip_v   = 1'b0;
`endif
    load_rom(0);
    #12;
    check("rst.busy", bus.busy, 0, ok);
    check("rst.done", bus.done, 0, ok);
    check("rst.fb_we", bus.fb_we, 0, ok);
    check("rst.fb_addr", bus.fb_addr, 0, ok);
    check("rst.fb_data", bus.fb_data, 0, ok);
    check("rst.rom_addr", bus.rom_addr, 0, ok);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain opaque draw.
    run("basic", 10, 20, 1'b0, 1, 1);
    check("basic.count", wr_q.size(), 256, ok);
    check("basic.first_addr", wr_q.size() > 0 ? wr_q[0].addr : -1, 6410, ok);
    check("basic.first_data", wr_q.size() > 0 ? wr_q[0].data : -1, 1, ok);
    check("basic.first_cyc", wr_q.size() > 0 ? wr_q[0].cyc : -1, 3, ok);
    check("basic.last_addr", wr_q.size() > 0 ? wr_q[wr_q.size() - 1].addr : -1, 11225, ok);

    // Horizontal flip.
    run("fliph", 10, 20, 1'b1, 1, 1);
    check("fliph.first_data", wr_q.size() > 0 ? wr_q[0].data : -1, int'(rom_mem[15]), ok);
    check("fliph.ra1", rom_seen[1], 15, ok);
    check("fliph.ra17", rom_seen[17], 31, ok);

    // Transparent left half.
    load_rom(1);
    run("transp", 0, 0, 1'b0, 1, 1);
    check("transp.count", wr_q.size(), 128, ok);

    // Clipping.
    load_rom(0);
    run("clip_bl", -8, 232, 1'b0, 1, 1);
    check("clip_bl.count", wr_q.size(), 64, ok);
    run("clip_off", 320, 0, 1'b0, 1, 1);
    check("clip_off.count", wr_q.size(), 0, ok);

    // start held: one draw during busy, a second from the first idle cycle.
    run("held", 30, 40, 1'b0, 300, 2);
    check("held.busy260", busy_seen[260], 0, ok);

    // Reset in the middle of a draw.
    load_rom(2);
    @(posedge clk);
    #1;
    bus.sprite_x = 11'd50;
    bus.sprite_y = 11'd60;
    bus.flip_h   = 1'b0;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.fb_we", bus.fb_we, 0, ok);
    check("abort.busy", bus.busy, 0, ok);
    check("abort.done", bus.done, 0, ok);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_q.delete();
    done_q.delete();
    t0     = abs_cyc;
    log_en = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    log_en = 1'b0;
    check("abort.ndone", done_q.size(), 0, ok);
    check("abort.nwr", wr_q.size(), 0, ok);
    run("after_abort", 5, 7, 1'b0, 1, 1);

    // Randomised draws against the pixel-list model.
    for (int i = 0; i < 5; i++) begin
      load_rom(2);
      run("rand", int'($urandom_range(360)) - 20, int'($urandom_range(270)) - 20,
          1'($urandom_range(1)), 1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Writer-side counterpart to the sprite display path: copies one SPR_W x SPR_H palette-indexed sprite from its sprite ROM into the indexed framebuffer RAM at a given screen position.
- The VGA path later reads that framebuffer through the palette.
- Handles horizontal flip, so one ROM serves both left- and right-facing goombas. Handles the transparent index and screen-edge clipping.
- Started per sprite by the game/render sequencer.

Parameters:
SPR_W, 16, sprite width in pixels
SPR_H, 16, sprite height in pixels
FB_W, 320, framebuffer width in pixels
FB_H, 240, framebuffer height in pixels
ROM_AW, 8, sprite ROM address width (covers SPR_W*SPR_H)
FB_AW, 17, framebuffer address width (covers FB_W*FB_H)
TRANSPARENT_IDX, 0, palette index that is never written

Ports:
vga_clk  in  1  sole clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to draw; sampled only in IDLE
sprite_x  in  11  signed screen X of sprite top-left; latched on accepted start
sprite_y  in  11  signed screen Y of sprite top-left; latched on accepted start
flip_h  in  1  mirror sprite horizontally; latched on accepted start
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse when the final write has been issued
rom_addr  out  ROM_AW  sprite ROM read address
rom_q  in  4  sprite ROM data; valid one cycle after rom_addr (synchronous ROM)
fb_we  out  1  framebuffer write enable
fb_addr  out  FB_AW  framebuffer write address
fb_data  out  4  palette index to write

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, rom_addr=0; col/row counters and pipeline valids cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches sprite_x, sprite_y and flip_h, clears col and row, and moves to RUN. Otherwise the FSM stays in IDLE.
- RUN:
  - Each cycle issues one pixel: rom_addr = row*SPR_W + (flip_h ? SPR_W-1-col : col), registered from the counters.
  - col increments and wraps to 0 at SPR_W-1, incrementing row.
  - After issuing (col=SPR_W-1, row=SPR_H-1), the FSM goes to DRAIN.
- Pipeline:
  - Stage 1 carries the target coordinates: tx = sprite_x + col and ty = sprite_y + row, as 11-bit signed values, plus a valid bit, aligned with rom_addr.
  - Stage 2 (rom_q valid) registers the write:
    - fb_we = valid AND 0<=tx<FB_W AND 0<=ty<FB_H AND rom_q!=TRANSPARENT_IDX.
    - fb_addr = ty*FB_W + tx, truncated to FB_AW bits.
    - fb_data = rom_q.
  - When fb_we=0, fb_addr and fb_data hold their previous values.
  - Latency: the write for pixel k appears 2 cycles after its rom_addr cycle.
- DRAIN: stays 2 cycles until both pipeline valids are clear, then DONE.
- DONE: done=1 for exactly one cycle, busy still 1. The next cycle is IDLE with busy=0.
- Timing for a 16x16 sprite with start sampled in cycle 0:
  - rom_addr cycles 1..256.
  - Possible fb_we cycles 3..258.
  - done in cycle 259; busy high in cycles 1..259.
- start while busy is ignored; a start in the DONE cycle is also ignored. start re-sampled in IDLE is accepted.
- Clipping is per pixel. A sprite fully off-screen performs zero writes but still runs the full duration and pulses done.
- fb_we is never asserted outside stage-2 valid.
- Reset mid-operation aborts the draw immediately: no further writes and no done pulse.

Optional Feature:
- Macro: SPRITE_BLITTER_FLIP_V_EN.
- Defined:
  - Adds input port flip_v (1 bit), latched on an accepted start.
  - The ROM row becomes (flip_v ? SPR_H-1-row : row); target ty is unchanged.
  - flip_h and flip_v combine independently.
- Undefined: no flip_v port; rows are always read top-down.
- Timing is identical in both builds.

Test Plan:
- ROM q=(addr%15)+1 (all opaque), start at (10,20), flip_h=0 -> exactly 256 fb_we pulses. First write: fb_addr=6410, fb_data=1, in cycle 3. Last write: fb_addr=(35*320)+25=11225. done in cycle 259 only; busy high in cycles 1..259.
- Same ROM, flip_h=1 -> first write: fb_addr=6410 with fb_data equal to ROM[15]. rom_addr sequence starts 15,14,...,0,31,...
- ROM with index 0 in the left half of each row, start (0,0) -> 128 writes, all at tx in 8..15. No write carries fb_data=0.
- Clipping: start (-8,232), all opaque -> only tx 0..7 and ty 232..239 are written, giving 64 writes. Start (320,0) -> 0 writes and done still in cycle 259.
- start held high for 300 cycles -> exactly one draw accepted during busy; a second draw begins at the first IDLE cycle (260). Its first rom_addr is in cycle 261.
- reset_n low at cycle 100 -> fb_we=0, busy=0, done=0 immediately. After release, no done pulse occurs. A new start draws normally from pixel 0.
